// File: rtl/mem_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_fabric
// Brief    : picorv32 native-port interconnect to NUM_SLAVES channels with
//            address decode, per-slave wait states, read mux and sticky error.
//            Optional macro BUS_TIMEOUT_EN adds a WAIT-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_fabric #(
    parameter int          NUM_SLAVES     = 5,
    parameter int          DEC_HI         = 15,
    parameter int          DEC_LO         = 12,
    parameter logic [63:0] SLAVE_LAT      = {16{4'd0}},
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_valid,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic                     m_ready,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_cs,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_wdata,
    output logic [31:0]              s_addr,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready_ext,
    input  logic                     err_clr,
    output logic                     err,
    output logic [31:0]              err_addr
);

    localparam int c_SEL_W = DEC_HI - DEC_LO + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_SEL_W-1:0]   w_sel, r_sel, w_sel_nxt;
    logic                 w_mapped;
    logic [3:0]           r_cnt, w_cnt_nxt;
    logic [3:0]           w_lat_new, w_lat_cur;
    logic                 w_ext_cur;
    logic [31:0]          w_rdata_cur;
    logic                 r_resp_err, w_resp_err_nxt;
    logic                 w_err_evt;
    logic                 r_err;
    logic [31:0]          r_err_addr;
    logic                 w_tmo;

    assign w_sel    = m_addr[DEC_HI:DEC_LO];
    assign w_mapped = (32'(w_sel) < 32'(NUM_SLAVES));

    // Per-slave lookups: new decode drives chip select, latched decode drives response.
    always_comb begin
        s_cs        = '0;
        w_lat_new   = 4'd0;
        w_lat_cur   = 4'd0;
        w_ext_cur   = 1'b0;
        w_rdata_cur = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_cs[i] = m_valid && w_mapped && (32'(w_sel) == 32'(i));
            if (32'(w_sel) == 32'(i)) begin
                w_lat_new = SLAVE_LAT[4*i +: 4];
            end
            if (32'(r_sel) == 32'(i)) begin
                w_lat_cur   = SLAVE_LAT[4*i +: 4];
                w_ext_cur   = s_ready_ext[i];
                w_rdata_cur = s_rdata[32*i +: 32];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] r_tcnt;

    assign w_tmo = (r_tcnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= 16'd0;
        end else if (r_state == ST_WAIT) begin
            r_tcnt <= r_tcnt + 16'd1;
        end else begin
            r_tcnt <= 16'd0;
        end
    end
`else
    logic [15:0] w_unused_tmo;

    assign w_unused_tmo = 16'(TIMEOUT_CYCLES);
    assign w_tmo        = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_sel_nxt      = r_sel;
        w_resp_err_nxt = r_resp_err;
        w_err_evt      = 1'b0;
        s_wstrb        = 4'd0;
        case (r_state)
            ST_IDLE: begin
                w_resp_err_nxt = 1'b0;
                if (m_valid) begin
                    if (w_mapped) begin
                        // Only the accepting cycle strobes, so each write lands once.
                        s_wstrb     = m_wstrb;
                        w_sel_nxt   = w_sel;
                        w_cnt_nxt   = w_lat_new;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_resp_err_nxt = 1'b1;
                        w_err_evt      = 1'b1;
                        w_state_nxt    = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (!m_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo) begin
                    w_resp_err_nxt = 1'b1;
                    w_err_evt      = 1'b1;
                    w_state_nxt    = ST_RESP;
                end else if (w_lat_cur == 4'hF) begin
                    if (w_ext_cur) begin
                        w_state_nxt = ST_RESP;
                    end
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_sel      <= '0;
            r_resp_err <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_resp_err <= w_resp_err_nxt;
            // A new error outranks a simultaneous clear.
            if (w_err_evt) begin
                r_err      <= 1'b1;
                r_err_addr <= m_addr;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign m_ready  = (r_state == ST_RESP);
    assign m_rdata  = r_resp_err ? ERR_RDATA : w_rdata_cur;
    assign err      = r_err;
    assign err_addr = r_err_addr;
    assign s_addr   = m_addr;
    assign s_wdata  = m_wdata;

endmodule
`default_nettype wire
